// File: rtl/uart_time_reporter.sv
// Formats stopwatch/watch time snapshots as ASCII and streams them byte by byte
// into uart_tx over its start_trigger/tx_busy handshake, with round-robin arbitration.
`timescale 1ns/1ps
module uart_time_reporter #(
  parameter bit         ADD_CRLF = 1'b1,
  parameter logic [7:0] SW_TAG   = 8'h53,
  parameter logic [7:0] WT_TAG   = 8'h57
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_sw,
  input  logic       req_wt,
  input  logic [5:0] sw_min,
  input  logic [5:0] sw_sec,
  input  logic [6:0] sw_cs,
  input  logic [4:0] wt_hour,
  input  logic [5:0] wt_min,
  input  logic [5:0] wt_sec,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       grant_wt,
  output logic       done
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned FLD_W = 7;
  localparam logic [IDX_W-1:0] LAST_IDX = ADD_CRLF ? 4'd11 : 4'd9;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

  state_t           state, state_nxt;
  logic             pend_sw, pend_sw_nxt, pend_wt, pend_wt_nxt;
  logic             last_wt, last_wt_nxt;
  logic             grant_wt_nxt, busy_nxt, done_nxt, tx_start_nxt;
  logic [7:0]       tx_data_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [FLD_W-1:0] snap_a, snap_a_nxt, snap_b, snap_b_nxt, snap_c, snap_c_nxt;
  logic             pick_wt;

  // Two ASCII decimal digits; anything above 99 saturates to "99".
  function automatic logic [7:0] ascii_tens(input logic [FLD_W-1:0] v);
    logic [FLD_W-1:0] s;
    s = (v > 7'd99) ? 7'd99 : v;
    return 8'h30 + 8'(s / 7'd10);
  endfunction

  function automatic logic [7:0] ascii_ones(input logic [FLD_W-1:0] v);
    logic [FLD_W-1:0] s;
    s = (v > 7'd99) ? 7'd99 : v;
    return 8'h30 + 8'(s % 7'd10);
  endfunction

  // Fields a/b/c are min/sec/cs for the stopwatch and hour/min/sec for the watch.
  function automatic logic [7:0] msg_byte(input logic wt, input logic [FLD_W-1:0] a,
                                          input logic [FLD_W-1:0] b, input logic [FLD_W-1:0] c,
                                          input logic [IDX_W-1:0] i);
    logic [7:0] r;
    r = 8'h00;
    case (i)
      4'd0:    r = wt ? WT_TAG : SW_TAG;
      4'd1:    r = 8'h20;
      4'd2:    r = ascii_tens(a);
      4'd3:    r = ascii_ones(a);
      4'd4:    r = 8'h3A;
      4'd5:    r = ascii_tens(b);
      4'd6:    r = ascii_ones(b);
      4'd7:    r = wt ? 8'h3A : 8'h2E;
      4'd8:    r = ascii_tens(c);
      4'd9:    r = ascii_ones(c);
      4'd10:   r = 8'h0D;
      4'd11:   r = 8'h0A;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pend_sw  <= 1'b0;
      pend_wt  <= 1'b0;
      last_wt  <= 1'b1;
      grant_wt <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      idx      <= '0;
      snap_a   <= '0;
      snap_b   <= '0;
      snap_c   <= '0;
    end else begin
      state    <= state_nxt;
      pend_sw  <= pend_sw_nxt;
      pend_wt  <= pend_wt_nxt;
      last_wt  <= last_wt_nxt;
      grant_wt <= grant_wt_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      tx_start <= tx_start_nxt;
      tx_data  <= tx_data_nxt;
      idx      <= idx_nxt;
      snap_a   <= snap_a_nxt;
      snap_b   <= snap_b_nxt;
      snap_c   <= snap_c_nxt;
    end
  end

  // tx_start/tx_data are registered on the edge that enters LOAD, so they are valid during LOAD.
  always_comb begin
    state_nxt    = state;
    pend_sw_nxt  = pend_sw | req_sw;
    pend_wt_nxt  = pend_wt | req_wt;
    last_wt_nxt  = last_wt;
    grant_wt_nxt = grant_wt;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    idx_nxt      = idx;
    snap_a_nxt   = snap_a;
    snap_b_nxt   = snap_b;
    snap_c_nxt   = snap_c;
    pick_wt      = pend_wt & (~pend_sw | ~last_wt);
    case (state)
      IDLE: begin
        if (pend_sw || pend_wt) begin
          grant_wt_nxt = pick_wt;
          last_wt_nxt  = pick_wt;
          busy_nxt     = 1'b1;
          if (pick_wt) begin
            pend_wt_nxt = req_wt;
            snap_a_nxt  = 7'(wt_hour);
            snap_b_nxt  = 7'(wt_min);
            snap_c_nxt  = 7'(wt_sec);
          end else begin
            pend_sw_nxt = req_sw;
            snap_a_nxt  = 7'(sw_min);
            snap_b_nxt  = 7'(sw_sec);
            snap_c_nxt  = sw_cs;
          end
          tx_start_nxt = 1'b1;
          tx_data_nxt  = msg_byte(pick_wt, snap_a_nxt, snap_b_nxt, snap_c_nxt, idx);
          state_nxt    = LOAD;
        end
      end
      LOAD: state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (tx_busy) state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            idx_nxt      = idx + IDX_W'(1);
            tx_start_nxt = 1'b1;
            tx_data_nxt  = msg_byte(grant_wt, snap_a, snap_b, snap_c, idx_nxt);
            state_nxt    = LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_time_reporter.sv
// Bench for uart_time_reporter: two instances (with and without CR/LF), each driving
// a simple uart_tx busy model, checked against a message-level byte scoreboard.
`timescale 1ns/1ps
module tb_uart_time_reporter;

  localparam int UART_LEN = 5;

  typedef struct packed {
    logic       first;
    logic       last;
    logic       wt;
    logic [7:0] b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_sw, req_wt;
  logic [5:0] sw_min, sw_sec, wt_min, wt_sec;
  logic [6:0] sw_cs;
  logic [4:0] wt_hour;
  logic [1:0] tx_busy, tx_start, busy, grant_wt, done;
  logic [7:0] tx_data0, tx_data1;
  logic [3:0] ucnt0, ucnt1;

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [1:0] end_due = 2'b00;
  int   starts[2];
  int   dones[2];

  logic [7:0] pin_sw[12] = '{8'h53, 8'h20, 8'h30, 8'h33, 8'h3A, 8'h30, 8'h37, 8'h2E,
                             8'h34, 8'h32, 8'h0D, 8'h0A};
  logic [7:0] pin_wt[10] = '{8'h57, 8'h20, 8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A,
                             8'h30, 8'h35};

  always #5 clk = ~clk;

  uart_time_reporter #(.ADD_CRLF(1'b1)) u0 (
    .clk(clk), .rst(rst), .req_sw(req_sw[0]), .req_wt(req_wt[0]),
    .sw_min(sw_min), .sw_sec(sw_sec), .sw_cs(sw_cs),
    .wt_hour(wt_hour), .wt_min(wt_min), .wt_sec(wt_sec),
    .tx_busy(tx_busy[0]), .tx_start(tx_start[0]), .tx_data(tx_data0),
    .busy(busy[0]), .grant_wt(grant_wt[0]), .done(done[0])
  );

  uart_time_reporter #(.ADD_CRLF(1'b0)) u1 (
    .clk(clk), .rst(rst), .req_sw(req_sw[1]), .req_wt(req_wt[1]),
    .sw_min(sw_min), .sw_sec(sw_sec), .sw_cs(sw_cs),
    .wt_hour(wt_hour), .wt_min(wt_min), .wt_sec(wt_sec),
    .tx_busy(tx_busy[1]), .tx_start(tx_start[1]), .tx_data(tx_data1),
    .busy(busy[1]), .grant_wt(grant_wt[1]), .done(done[1])
  );

  // uart_tx stand-in: busy rises the cycle after a start and lasts UART_LEN cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ucnt0 <= 4'd0;
      ucnt1 <= 4'd0;
    end else begin
      if (ucnt0 != 4'd0) ucnt0 <= ucnt0 - 4'd1;
      else if (tx_start[0]) ucnt0 <= 4'(UART_LEN);
      if (ucnt1 != 4'd0) ucnt1 <= ucnt1 - 4'd1;
      else if (tx_start[1]) ucnt1 <= 4'(UART_LEN);
    end
  end
  assign tx_busy[0] = (ucnt0 != 4'd0);
  assign tx_busy[1] = (ucnt1 != 4'd0);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Message-level model: byte i of a report from plain decimal arithmetic.
  function automatic logic [7:0] model_byte(input bit wt, input int a, input int b,
                                            input int c, input int i);
    int f[3];
    int v;
    f = '{a, b, c};
    if (i == 0) return wt ? 8'h57 : 8'h53;
    if (i == 1) return 8'h20;
    if (i == 4) return 8'h3A;
    if (i == 7) return wt ? 8'h3A : 8'h2E;
    if (i == 10) return 8'h0D;
    if (i == 11) return 8'h0A;
    v = f[(i - 2) / 3];
    if (v > 99) v = 99;
    return 8'(48 + (((i - 2) % 3 == 0) ? v / 10 : v % 10));
  endfunction

  task automatic expect_msg(input int k, input bit wt, input int a, input int b, input int c);
    exp_t e;
    int n;
    n = (k == 0) ? 12 : 10;
    for (int i = 0; i < n; i++) begin
      e.first = (i == 0);
      e.last  = (i == n - 1);
      e.wt    = wt;
      e.b     = model_byte(wt, a, b, c, i);
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic check_inst(input int k);
    exp_t e;
    bit have;
    logic [7:0] d;
    d = (k == 0) ? tx_data0 : tx_data1;
    if (tx_start[k]) begin
      starts[k]++;
      chk("start_while_uart_idle", int'(tx_busy[k]), 0);
      chk("busy_during_start", int'(busy[k]), 1);
      have = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
      chk("start_has_expected_byte", int'(have), 1);
      if (have) begin
        if (k == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk("tx_data", int'(d), int'(e.b));
        if (e.first) begin
          chk("prev_msg_done_before_new", int'(end_due[k]), 0);
          chk("grant_wt", int'(grant_wt[k]), int'(e.wt));
        end
        if (e.last) end_due[k] = 1'b1;
      end
    end
    if (done[k]) begin
      dones[k]++;
      chk("done_after_last_byte", int'(end_due[k]), 1);
      chk("busy_low_at_done", int'(busy[k]), 0);
      end_due[k] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check_inst(0);
      check_inst(1);
    end
  end

  task automatic pulse(input int k, input bit s, input bit w);
    @(negedge clk);
    req_sw[k] = s;
    req_wt[k] = w;
    @(negedge clk);
    req_sw[k] = 1'b0;
    req_wt[k] = 1'b0;
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || end_due != 2'b00) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_within_budget", int'(n < budget), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n;
    n = 0;
    while (starts[0] < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("start_count_reached", int'(starts[0] >= target), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, d0;
    starts = '{0, 0};
    dones  = '{0, 0};
    rst = 1'b1;
    req_sw = 2'b00;
    req_wt = 2'b00;
    sw_min = 6'd3; sw_sec = 6'd7; sw_cs = 7'd42;
    wt_hour = 5'd23; wt_min = 6'd59; wt_sec = 6'd5;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_tx_start", int'(tx_start[k]), 0);
      chk("rst_busy", int'(busy[k]), 0);
      chk("rst_grant_wt", int'(grant_wt[k]), 0);
      chk("rst_done", int'(done[k]), 0);
    end
    chk("rst_tx_data", int'(tx_data0), 0);
    chk("rst_pend", int'({u0.pend_sw, u0.pend_wt}), 0);

    // Hand-computed byte strings pin the model.
    for (int i = 0; i < 12; i++) chk("pin_sw_msg", int'(model_byte(0, 3, 7, 42, i)), int'(pin_sw[i]));
    for (int i = 0; i < 10; i++) chk("pin_wt_msg", int'(model_byte(1, 23, 59, 5, i)), int'(pin_wt[i]));
    chk("pin_sat_c1", int'(model_byte(0, 0, 0, 120, 8)), 8'h39);
    chk("pin_sat_c0", int'(model_byte(0, 0, 0, 120, 9)), 8'h39);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Stopwatch single with first-byte latency.
    expect_msg(0, 0, 3, 7, 42);
    @(negedge clk);
    req_sw[0] = 1'b1;
    @(negedge clk);
    req_sw[0] = 1'b0;
    chk("lat_no_start_yet", int'(tx_start[0]), 0);
    chk("pend_sw_set", int'(u0.pend_sw), 1);
    @(negedge clk);
    chk("lat_first_start", int'(tx_start[0]), 1);
    chk("busy_at_grant", int'(busy[0]), 1);
    chk("pend_sw_cleared", int'(u0.pend_sw), 0);
    wait_quiet(400);
    chk("sw_single_starts", starts[0], 12);
    chk("sw_single_dones", dones[0], 1);
    chk("sw_single_busy_after", int'(busy[0]), 0);

    // Watch single, no CR/LF.
    expect_msg(1, 1, 23, 59, 5);
    pulse(1, 1'b0, 1'b1);
    wait_quiet(400);
    chk("wt_single_starts", starts[1], 10);
    chk("wt_single_dones", dones[1], 1);
    chk("wt_single_grant_held", int'(grant_wt[1]), 1);

    // Simultaneous requests right after reset: stopwatch first.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    d0 = dones[0];
    expect_msg(0, 0, 3, 7, 42);
    expect_msg(0, 1, 23, 59, 5);
    pulse(0, 1'b1, 1'b1);
    @(negedge clk);
    chk("sim_pend_sw_cleared", int'(u0.pend_sw), 0);
    chk("sim_pend_wt_held", int'(u0.pend_wt), 1);
    wait_quiet(600);
    chk("sim_dones", dones[0] - d0, 2);
    chk("sim_pend_wt_cleared", int'(u0.pend_wt), 0);

    // Snapshot and request collapse during a stopwatch message.
    sw_min = 6'd10; sw_sec = 6'd20; sw_cs = 7'd30;
    s0 = starts[0]; d0 = dones[0];
    expect_msg(0, 0, 10, 20, 30);
    pulse(0, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sw_sec = 6'(41 + i);
      pulse(0, 1'b1, 1'b0);
      repeat (8) @(negedge clk);
    end
    chk("collapse_pend_sw", int'(u0.pend_sw), 1);
    expect_msg(0, 0, 10, 43, 30);
    wait_quiet(600);
    chk("collapse_starts", starts[0] - s0, 24);
    chk("collapse_dones", dones[0] - d0, 2);

    // Saturation of centiseconds.
    sw_min = 6'd59; sw_sec = 6'd0; sw_cs = 7'd120;
    expect_msg(0, 0, 59, 0, 120);
    pulse(0, 1'b1, 1'b0);
    wait_quiet(400);

    // Tie after a stopwatch grant goes to the watch.
    wt_hour = 5'd7; wt_min = 6'd63; wt_sec = 6'd0;
    expect_msg(0, 1, 7, 63, 0);
    expect_msg(0, 0, 59, 0, 120);
    pulse(0, 1'b1, 1'b1);
    wait_quiet(600);

    // Reset mid-message aborts and drops the pending request.
    wt_hour = 5'd12; wt_min = 6'd34; wt_sec = 6'd56;
    s0 = starts[0]; d0 = dones[0];
    expect_msg(0, 1, 12, 34, 56);
    pulse(0, 1'b0, 1'b1);
    wait_starts(s0 + 2, 200);
    req_sw[0] = 1'b1;
    @(negedge clk);
    req_sw[0] = 1'b0;
    wait_starts(s0 + 4, 200);
    rst = 1'b1;
    #1;
    chk("abort_tx_start", int'(tx_start[0]), 0);
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_pend", int'({u0.pend_sw, u0.pend_wt}), 0);
    q0.delete();
    end_due[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_more_bytes", starts[0] - s0, 4);
    chk("abort_no_done", dones[0] - d0, 0);
    expect_msg(0, 1, 12, 34, 56);
    pulse(0, 1'b0, 1'b1);
    wait_quiet(400);
    chk("after_abort_starts", starts[0] - s0, 16);
    chk("after_abort_dones", dones[0] - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
